hwpe_ctrl_periph_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one HWPE peripheral (register-file) target port between NB_MASTERS peripheral initiators, e.g. a core-side and a debug-side bus both configuring the same accelerator controller. It forwards the request of the selected initiator to the target and holds that selection until the target grants. It tracks outstanding transactions in an in-order FIFO so that each response (r_valid, r_data, r_id) is steered back to the initiator that issued it.

---
 rtl/hwpe_ctrl_periph_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_hwpe_ctrl_periph_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_periph_rr_arbiter.sv
// Round-robin arbiter sharing one HWPE peripheral target port between NB_MASTERS initiators.
// It holds the selection until the target grants and routes responses back in grant order.
module hwpe_ctrl_periph_rr_arbiter #(
    parameter int unsigned NB_MASTERS      = 4,
    parameter int unsigned ID_WIDTH        = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_MASTERS-1:0]                  m_req_i,
    output logic [NB_MASTERS-1:0]                  m_gnt_o,
    input  logic [NB_MASTERS*32-1:0]               m_add_i,
    input  logic [NB_MASTERS-1:0]                  m_we_n_i,
    input  logic [NB_MASTERS*4-1:0]                m_be_i,
    input  logic [NB_MASTERS*32-1:0]               m_data_i,
    input  logic [NB_MASTERS*ID_WIDTH-1:0]         m_id_i,
    output logic [31:0]                            m_r_data_o,
    output logic [NB_MASTERS-1:0]                  m_r_valid_o,
    output logic [ID_WIDTH-1:0]                    m_r_id_o,
    output logic                                   s_req_o,
    output logic [31:0]                            s_add_o,
    output logic                                   s_we_n_o,
    output logic [3:0]                             s_be_o,
    output logic [31:0]                            s_data_o,
    output logic [ID_WIDTH-1:0]                    s_id_o,
    input  logic                                   s_gnt_i,
    input  logic [31:0]                            s_r_data_i,
    input  logic                                   s_r_valid_i,
    input  logic [ID_WIDTH-1:0]                    s_r_id_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   resp_err_o
);

    localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] ptr_q;
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             sel_active;
    logic             fifo_full;
    logic             hs;
    logic             pop;
    logic [IDX_W-1:0] head;

    function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Rotating priority search starting at ptr; a pending lock overrides it.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        sel   = lock_idx_q;
        for (int unsigned i = 0; i < NB_MASTERS; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NB_MASTERS);
            if (!found && m_req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    assign sel_active    = lock_q | found;
    assign fifo_full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign s_req_o       = sel_active & m_req_i[sel] & ~fifo_full;
    assign hs            = s_req_o & s_gnt_i;
    assign head          = fifo_q[rd_ptr_q];
    assign pop           = s_r_valid_i & (cnt_q != '0);
    assign outstanding_o = cnt_q;
    assign m_r_data_o    = s_r_data_i;
    assign m_r_id_o      = s_r_id_i;

    // Request bundle mux and per-initiator grant/response steering.
    always_comb begin
        s_add_o     = '0;
        s_we_n_o    = 1'b0;
        s_be_o      = '0;
        s_data_o    = '0;
        s_id_o      = '0;
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (sel_active) begin
            s_add_o  = m_add_i[32'(sel)*32 +: 32];
            s_we_n_o = m_we_n_i[sel];
            s_be_o   = m_be_i[32'(sel)*4 +: 4];
            s_data_o = m_data_i[32'(sel)*32 +: 32];
            s_id_o   = m_id_i[32'(sel)*ID_WIDTH +: ID_WIDTH];
        end
        if (hs) begin
            m_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            m_r_valid_o[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            resp_err_o <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (hs) begin
                ptr_q            <= (sel == IDX_W'(NB_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
                lock_q           <= 1'b0;
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= fifo_inc(wr_ptr_q);
            end else if (s_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= fifo_inc(rd_ptr_q);
            end
            if (hs && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !hs) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // Response with nothing outstanding is a sticky error.
            if (s_r_valid_i && (cnt_q == '0)) begin
                resp_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_periph_rr_arbiter.sv
// Bench for hwpe_ctrl_periph_rr_arbiter: directed vector table plus random traffic
// against a queue-based reference model of the arbitration and response routing.
module tb_hwpe_ctrl_periph_rr_arbiter;

    localparam int NBM  = 4;
    localparam int IDW  = 2;
    localparam int MAXO = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NBM-1:0]    m_req_i;
    logic [NBM-1:0]    m_gnt_o;
    logic [NBM*32-1:0] m_add_i;
    logic [NBM-1:0]    m_we_n_i;
    logic [NBM*4-1:0]  m_be_i;
    logic [NBM*32-1:0] m_data_i;
    logic [NBM*IDW-1:0] m_id_i;
    logic [31:0]       m_r_data_o;
    logic [NBM-1:0]    m_r_valid_o;
    logic [IDW-1:0]    m_r_id_o;
    logic              s_req_o;
    logic [31:0]       s_add_o;
    logic              s_we_n_o;
    logic [3:0]        s_be_o;
    logic [31:0]       s_data_o;
    logic [IDW-1:0]    s_id_o;
    logic              s_gnt_i;
    logic [31:0]       s_r_data_i;
    logic              s_r_valid_i;
    logic [IDW-1:0]    s_r_id_i;
    logic [1:0]        outstanding_o;
    logic              resp_err_o;

    hwpe_ctrl_periph_rr_arbiter #(
        .NB_MASTERS(NBM), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_add_i(m_add_i), .m_we_n_i(m_we_n_i),
        .m_be_i(m_be_i), .m_data_i(m_data_i), .m_id_i(m_id_i),
        .m_r_data_o(m_r_data_o), .m_r_valid_o(m_r_valid_o), .m_r_id_o(m_r_id_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_we_n_o(s_we_n_o), .s_be_o(s_be_o),
        .s_data_o(s_data_o), .s_id_o(s_id_o),
        .s_gnt_i(s_gnt_i), .s_r_data_i(s_r_data_i), .s_r_valid_i(s_r_valid_i), .s_r_id_i(s_r_id_i),
        .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Per-initiator payload, packed onto the flat ports each cycle.
    logic [31:0] add_a  [NBM];
    logic [31:0] data_a [NBM];
    logic [3:0]  be_a   [NBM];
    logic        wen_a  [NBM];

    // Reference model state.
    int mdl_ptr;
    bit mdl_lock;
    int mdl_lock_idx;
    int mdl_q[$];
    bit mdl_err;

    typedef struct {
        bit          do_rst;
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic        exp_sreq;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
        logic [1:0]  exp_out;
        logic        exp_err;
        logic [31:0] exp_add;
    } vec_t;

    vec_t tbl[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input bit r, input logic [3:0] q, input logic g, input logic v,
                                input logic es, input logic [3:0] eg, input logic [3:0] ev,
                                input logic [1:0] eo, input logic ee, input logic [31:0] ea);
        vec_t t;
        t.do_rst = r; t.req = q; t.gnt = g; t.rv = v;
        t.exp_sreq = es; t.exp_gnt = eg; t.exp_rv = ev; t.exp_out = eo; t.exp_err = ee; t.exp_add = ea;
        return t;
    endfunction

    task automatic drive_payload();
        for (int i = 0; i < NBM; i++) begin
            m_add_i[i*32 +: 32]  = add_a[i];
            m_data_i[i*32 +: 32] = data_a[i];
            m_be_i[i*4 +: 4]     = be_a[i];
            m_we_n_i[i]          = wen_a[i];
            m_id_i[i*IDW +: IDW] = IDW'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        m_req_i = '0; s_gnt_i = 1'b0; s_r_valid_i = 1'b0;
        #3;
        rst_ni = 1'b1;
        mdl_ptr = 0; mdl_lock = 0; mdl_lock_idx = 0; mdl_q.delete(); mdl_err = 0;
    endtask

    // One clock: drive, compare settled outputs against the model, then advance the model.
    task automatic run_cycle(input logic [3:0] req, input logic gnt, input logic rv,
                             input logic [31:0] rdata, input logic [1:0] rid);
        int  sel;
        bit  full, e_sreq, e_hs, e_pop;
        logic [3:0] e_gnt, e_rv;
        @(negedge clk_i);
        drive_payload();
        m_req_i = req; s_gnt_i = gnt; s_r_valid_i = rv; s_r_data_i = rdata; s_r_id_i = rid;
        #1;
        sel = -1;
        if (mdl_lock) sel = mdl_lock_idx;
        else for (int k = 0; k < NBM; k++) if (sel < 0 && req[(mdl_ptr + k) % NBM]) sel = (mdl_ptr + k) % NBM;
        full   = (mdl_q.size() == MAXO);
        e_sreq = (sel >= 0) && req[sel] && !full;
        e_hs   = e_sreq && gnt;
        e_pop  = rv && (mdl_q.size() > 0);
        e_gnt  = e_hs ? 4'(1 << sel) : 4'b0;
        e_rv   = e_pop ? 4'(1 << mdl_q[0]) : 4'b0;
        chk("s_req", 32'(s_req_o), 32'(e_sreq));
        chk("m_gnt", 32'(m_gnt_o), 32'(e_gnt));
        chk("m_r_valid", 32'(m_r_valid_o), 32'(e_rv));
        chk("outstanding", 32'(outstanding_o), 32'(mdl_q.size()));
        chk("resp_err", 32'(resp_err_o), 32'(mdl_err));
        chk("r_data", m_r_data_o, rdata);
        chk("r_id", 32'(m_r_id_o), 32'(rid));
        if (e_sreq) begin
            chk("s_add", s_add_o, add_a[sel]);
            chk("s_data", s_data_o, data_a[sel]);
            chk("s_be", 32'(s_be_o), 32'(be_a[sel]));
            chk("s_we_n", 32'(s_we_n_o), 32'(wen_a[sel]));
            chk("s_id", 32'(s_id_o), 32'(sel));
        end else if (sel < 0) begin
            chk("idle_bundle", s_add_o | s_data_o | 32'(s_be_o) | 32'(s_id_o) | 32'(s_we_n_o), 32'd0);
        end
        if (rv && mdl_q.size() == 0) mdl_err = 1;
        if (e_pop) void'(mdl_q.pop_front());
        if (e_hs) begin
            mdl_q.push_back(sel);
            mdl_ptr  = (sel + 1) % NBM;
            mdl_lock = 0;
        end else if (e_sreq) begin
            mdl_lock     = 1;
            mdl_lock_idx = sel;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        m_req_i = '0; s_gnt_i = 1'b0; s_r_valid_i = 1'b0; s_r_data_i = '0; s_r_id_i = '0;
        for (int i = 0; i < NBM; i++) begin
            add_a[i] = 32'h10 + 32'(i) * 32'h100;
            data_a[i] = 32'hA0 + 32'(i);
            be_a[i] = 4'hF;
            wen_a[i] = 1'b1;
        end
        drive_payload();

        //             rst req     gnt  rv    sreq gnt     rv      out   err   add
        tbl.push_back(mk(1, 4'b0001, 1, 0,   1, 4'b0001, 4'b0000, 2'd0, 0, 32'h010));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0001, 2'd1, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 0,   0, 4'b0000, 4'b0000, 2'd0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0100, 0, 0,   1, 4'b0000, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0101, 0, 0,   1, 4'b0000, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0101, 0, 0,   1, 4'b0000, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0101, 1, 0,   1, 4'b0100, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0001, 1, 0,   1, 4'b0001, 4'b0000, 2'd1, 0, 32'h010));
        tbl.push_back(mk(0, 4'b0010, 1, 0,   0, 4'b0000, 4'b0000, 2'd2, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 1, 1,   0, 4'b0000, 4'b0100, 2'd2, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 1, 0,   1, 4'b0010, 4'b0000, 2'd1, 0, 32'h110));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0001, 2'd2, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0010, 2'd1, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0000, 2'd0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 0,   0, 4'b0000, 4'b0000, 2'd0, 1, 32'h0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   1, 4'b0001, 4'b0000, 2'd0, 0, 32'h010));
        tbl.push_back(mk(0, 4'b1111, 1, 1,   1, 4'b0010, 4'b0001, 2'd1, 0, 32'h110));
        tbl.push_back(mk(0, 4'b1111, 1, 1,   1, 4'b0100, 4'b0010, 2'd1, 0, 32'h210));
        tbl.push_back(mk(0, 4'b1111, 1, 1,   1, 4'b1000, 4'b0100, 2'd1, 0, 32'h310));
        tbl.push_back(mk(0, 4'b1111, 1, 1,   1, 4'b0001, 4'b1000, 2'd1, 0, 32'h010));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0001, 2'd1, 0, 32'h0));
        tbl.push_back(mk(1, 4'b0100, 0, 0,   1, 4'b0000, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0001, 1, 0,   0, 4'b0000, 4'b0000, 2'd0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0101, 1, 0,   1, 4'b0100, 4'b0000, 2'd0, 0, 32'h210));
        tbl.push_back(mk(0, 4'b0001, 1, 0,   1, 4'b0001, 4'b0000, 2'd1, 0, 32'h010));
        tbl.push_back(mk(1, 4'b1010, 1, 0,   1, 4'b0010, 4'b0000, 2'd0, 0, 32'h110));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0010, 2'd1, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 1,   0, 4'b0000, 4'b0000, 2'd0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 0, 0,   0, 4'b0000, 4'b0000, 2'd0, 1, 32'h0));

        foreach (tbl[n]) begin
            if (tbl[n].do_rst) do_reset();
            run_cycle(tbl[n].req, tbl[n].gnt, tbl[n].rv, 32'hDEADBEEF, 2'd1);
            chk($sformatf("tbl%0d_s_req", n), 32'(s_req_o), 32'(tbl[n].exp_sreq));
            chk($sformatf("tbl%0d_m_gnt", n), 32'(m_gnt_o), 32'(tbl[n].exp_gnt));
            chk($sformatf("tbl%0d_m_r_valid", n), 32'(m_r_valid_o), 32'(tbl[n].exp_rv));
            chk($sformatf("tbl%0d_outstanding", n), 32'(outstanding_o), 32'(tbl[n].exp_out));
            chk($sformatf("tbl%0d_resp_err", n), 32'(resp_err_o), 32'(tbl[n].exp_err));
            if (tbl[n].exp_sreq) chk($sformatf("tbl%0d_s_add", n), s_add_o, tbl[n].exp_add);
        end

        // Random traffic; responses only once something is outstanding.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] rq;
            logic g, v;
            for (int i = 0; i < NBM; i++) begin
                add_a[i]  = $urandom;
                data_a[i] = $urandom;
                be_a[i]   = 4'($urandom_range(0, 15));
                wen_a[i]  = 1'($urandom_range(0, 1));
            end
            rq = 4'($urandom_range(0, 15));
            g  = ($urandom_range(0, 3) != 0);
            v  = (mdl_q.size() > 0) && ($urandom_range(0, 2) != 0);
            run_cycle(rq, g, v, $urandom, 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
